// File: rtl/calc_result_fifo_if.sv
// Handshake bundle between the calculator FSM/datapath and the result consumer.
// Carries rd_par only when CALC_RESULT_PARITY_EN is defined.
interface calc_result_fifo_if #(
    parameter int unsigned DW    = 3,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          done;
    logic [DW-1:0] out;
    logic [1:0]    op;
    logic          clr_ovf;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW+1:0] rd_data;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          ovf;
`ifdef CALC_RESULT_PARITY_EN
    logic          rd_par;
`endif

    modport master (
        output done, out, op, clr_ovf, rd_ready,
`ifdef CALC_RESULT_PARITY_EN
        input  rd_par,
`endif
        input  rd_valid, rd_data, count, full, empty, ovf
    );

    modport slave (
        input  done, out, op, clr_ovf, rd_ready,
`ifdef CALC_RESULT_PARITY_EN
        output rd_par,
`endif
        output rd_valid, rd_data, count, full, empty, ovf
    );
endinterface

// File: rtl/calc_result_fifo.sv
// Result FIFO capturing {op, out} on each rising edge of the calculator done strobe.
// Define CALC_RESULT_PARITY_EN to store and present per-entry even parity on rd_par.
module calc_result_fifo #(
    parameter int unsigned DW    = 3,
    parameter int unsigned DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    calc_result_fifo_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = DW + 2;
`ifdef CALC_RESULT_PARITY_EN
    localparam int unsigned EW = PW + 1;
`else
    localparam int unsigned EW = PW;
`endif

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_n [DEPTH];
    logic [AW-1:0] head_q, head_n;
    logic [AW-1:0] tail_q, tail_n;
    logic [CW-1:0] count_q, count_n;
    logic          full_q, full_n;
    logic          empty_q, empty_n;
    logic          ovf_q, ovf_n;
    logic          done_q;
    logic [EW-1:0] rd_entry_q, rd_entry_n;
    logic [EW-1:0] entry_c;
    logic          push_c, pop_c, wr_c, drop_c;

    // A push into a full FIFO is still accepted when a pop frees the head slot.
    always_comb begin
        push_c = bus.done & ~done_q;
        pop_c  = ~empty_q & bus.rd_ready;
        wr_c   = push_c & (~full_q | pop_c);
        drop_c = push_c & full_q & ~pop_c;
`ifdef CALC_RESULT_PARITY_EN
        entry_c = {^{bus.op, bus.out}, bus.op, bus.out};
`else
        entry_c = {bus.op, bus.out};
`endif
        mem_n = mem_q;
        if (wr_c) begin
            mem_n[tail_q] = entry_c;
        end
        head_n  = pop_c ? head_q + AW'(1) : head_q;
        tail_n  = wr_c  ? tail_q + AW'(1) : tail_q;
        count_n = count_q + CW'(wr_c) - CW'(pop_c);
        full_n  = (count_n == CW'(DEPTH));
        empty_n = (count_n == '0);
        ovf_n   = drop_c | (ovf_q & ~bus.clr_ovf);
        // Head entry is registered from next-state storage so it appears one cycle after the push.
        rd_entry_n = mem_n[head_n];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            rd_entry_q <= '0;
        end else begin
            mem_q      <= mem_n;
            head_q     <= head_n;
            tail_q     <= tail_n;
            count_q    <= count_n;
            full_q     <= full_n;
            empty_q    <= empty_n;
            ovf_q      <= ovf_n;
            done_q     <= bus.done;
            rd_entry_q <= rd_entry_n;
        end
    end

    assign bus.rd_valid = ~empty_q;
    assign bus.rd_data  = rd_entry_q[PW-1:0];
    assign bus.count    = count_q;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.ovf      = ovf_q;
`ifdef CALC_RESULT_PARITY_EN
    assign bus.rd_par   = rd_entry_q[PW];
`endif
endmodule

// File: doc/calc_result_fifo.md
CALC_RESULT_FIFO -- requirements
Module: calc_result_fifo

Interface
REQ-001 SHALL have parameter DW, default 3, meaning calculator result width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of 2, >=2).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port DONE  input  1  calculator completion strobe from the FSM.
REQ-006 SHALL have port OUT  input  DW  calculator datapath result.
REQ-007 SHALL have port OP  input  2  opcode of the completed operation (11 add, 10 sub, 01 and, 00 xor).
REQ-008 SHALL have port CLR_OVF  input  1  clears sticky overflow flag.
REQ-009 SHALL have port RD_VALID  output  1  head entry available.
REQ-010 SHALL have port RD_READY  input  1  consumer accepts head entry.
REQ-011 SHALL have port RD_DATA  output  DW+2  head entry {OP, OUT}.
REQ-012 SHALL have port COUNT  output  log2(DEPTH)+1  stored entry count.
REQ-013 SHALL have ports FULL, EMPTY  output  1 each  COUNT==DEPTH / COUNT==0.
REQ-014 SHALL have port OVF  output  1  sticky: a capture was dropped while full.

Function
REQ-015 SHALL register DONE each cycle and generate push = DONE & ~DONE_q (rising edge), so DONE held high for N cycles captures exactly once.
REQ-016 SHALL write {OP, OUT} sampled in the push cycle into the tail entry; tail pointer wraps DEPTH-1 -> 0.
REQ-017 SHALL define pop = RD_VALID & RD_READY; on pop, head pointer advances with wrap DEPTH-1 -> 0.
REQ-018 SHALL drive RD_VALID = ~EMPTY; RD_DATA = head entry, registered storage, no combinational path from OUT/OP to RD_DATA.
REQ-019 Latency: entry SHALL appear on RD_VALID/RD_DATA the cycle after the push edge (no fall-through when empty).
REQ-020 Push and pop same cycle, not full: both SHALL occur, COUNT unchanged.
REQ-021 Push and pop same cycle while full: both SHALL occur, COUNT stays DEPTH, no overflow.
REQ-022 Push while full without pop: entry SHALL be dropped, storage unchanged, OVF set next cycle.
REQ-023 Pop while empty: impossible by REQ-017; RD_READY when empty SHALL have no effect.
REQ-024 OVF SHALL stay set until CLR_OVF; CLR_OVF and new overflow same cycle: OVF SHALL remain set.
REQ-025 RD_DATA SHALL hold stable while RD_VALID & ~RD_READY.

Reset
REQ-026 On RST high at a clock edge: head=tail=0, COUNT=0, EMPTY=1, FULL=0, RD_VALID=0, OVF=0, DONE_q=0.
REQ-027 RST SHALL override push/pop in the same cycle; reset mid-stream discards all entries.
REQ-028 RD_DATA SHALL be 0 after reset (storage cleared).
REQ-029 A DONE already high when RST deasserts SHALL count as a rising edge (DONE_q reset to 0).

Configuration
REQ-030 Macro CALC_RESULT_PARITY_EN defined: extra output RD_PAR (1 bit) = even parity (XOR reduction) of stored {OP, OUT}, computed at write and stored per entry; reset value 0.
REQ-031 Macro CALC_RESULT_PARITY_EN undefined: RD_PAR port and per-entry parity storage absent; all other behaviour identical.

Verification
REQ-032 Reset, then DONE 0->1 with OP=00, OUT=100 (110^010), DONE held 3 cycles -> one entry, next cycle RD_VALID=1, RD_DATA=00100, COUNT=1 (RD_PAR=1 if enabled).
REQ-033 Four DONE pulses OUT=000,100,010,100 / OP=11,10,01,00, RD_READY=0 -> FULL=1, COUNT=4; fifth pulse -> OVF=1, COUNT=4; drain yields 11000,10100,01010,00100 in order.
REQ-034 Full FIFO, DONE edge with RD_READY=1 same cycle -> COUNT stays 4, OVF stays 0, head advances, new entry last out.
REQ-035 Six push/pop pairs across pointer wrap -> data order preserved, EMPTY=1 after final pop.
REQ-036 COUNT=3 and OVF=1, assert RST one cycle -> COUNT=0, EMPTY=1, OVF=0, RD_VALID=0 next cycle.
REQ-037 OVF=1, pulse CLR_OVF alone -> OVF=0; CLR_OVF coincident with dropped push -> OVF=1.
